// File: rtl/nested_cause_stack_pkg.sv
// Shared definitions for the nested Cause stack: Cause register bit positions
// and the record saved for each exception nesting level.
package nested_cause_stack_pkg;

    localparam int BD_BIT  = 31;
    localparam int IP_LSB  = 8;
    localparam int EXC_LSB = 2;
    localparam int EXC_W   = 5;

    typedef struct packed {
        logic             bd;
        logic [EXC_W-1:0] exc_code;
        logic [1:0]       sw_ip;
    } cause_entry_t;

endpackage

// File: rtl/nested_cause_stack_cause_lifo.sv
// DEPTH-entry LIFO of saved Cause records; level counts the entries in use.
// Push has priority over pop; a push when full or a pop when empty is ignored.
module cause_lifo
    import nested_cause_stack_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  cause_entry_t     push_data_i,
    output cause_entry_t     pop_data_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o,
    output logic             empty_o
);

    cause_entry_t     mem_q [DEPTH];
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !push_i && !empty_o;

    always_comb begin
        level_d = level_q;
        if (do_push) begin
            level_d = level_q + LVL_W'(1);
        end else if (do_pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Top-of-stack is the entry just below level; compare-based select avoids index width issues.
    always_comb begin
        pop_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (level_q == LVL_W'(i + 1)) begin
                pop_data_o = mem_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && (level_q == LVL_W'(i))) begin
                    mem_q[i] <= push_data_i;
                end
            end
        end
    end

endmodule

// File: rtl/nested_cause_stack.sv
// Cause register with a nesting stack: exceptions save the current cause fields,
// eret restores them; hardware IP bits are sampled every cycle and never stacked.
module nested_cause_stack
    import nested_cause_stack_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int IP_WIDTH = 8,
    parameter int LVL_W    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                exc_valid,
    input  logic                exception_abort,
    input  logic                bd_p,
    input  logic [EXC_W-1:0]    exception_code,
    input  logic                eret,
    input  logic                wr_en,
    input  logic [31:0]         wr_data,
    input  logic [IP_WIDTH-3:0] ip,
    input  logic [IP_WIDTH-1:0] im,
    input  logic                ie,
    output logic [31:0]         read_data,
    output logic                irq,
    output logic [LVL_W-1:0]    level,
    output logic                nest_overflow,
    output logic                nest_underflow
);

    logic                bd_q, bd_d;
    logic [EXC_W-1:0]    exc_q, exc_d;
    logic [1:0]          sw_ip_q, sw_ip_d;
    logic [IP_WIDTH-3:0] hw_ip_q;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic                exc_eff;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    cause_entry_t        push_data;
    cause_entry_t        pop_data;
    logic [IP_WIDTH-1:0] ip_all;
    logic                unused_wr_bits;

    assign unused_wr_bits = ^{wr_data[31:10], wr_data[7:0]};

    assign exc_eff   = exc_valid && !exception_abort;
    assign push_data = '{bd: bd_q, exc_code: exc_q, sw_ip: sw_ip_q};

    cause_lifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_lifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (push_data),
        .pop_data_o  (pop_data),
        .level_o     (level),
        .full_o      (full),
        .empty_o     (empty)
    );

    // Exception beats eret beats mtc0; the losers in a cycle are dropped.
    always_comb begin
        bd_d    = bd_q;
        exc_d   = exc_q;
        sw_ip_d = sw_ip_q;
        ovf_d   = ovf_q;
        unf_d   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        if (exc_eff) begin
            push  = !full;
            ovf_d = ovf_q | full;
            bd_d  = bd_p;
            exc_d = exception_code;
        end else if (eret) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                pop     = 1'b1;
                bd_d    = pop_data.bd;
                exc_d   = pop_data.exc_code;
                sw_ip_d = pop_data.sw_ip;
            end
        end else if (wr_en) begin
            sw_ip_d = wr_data[9:8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bd_q    <= 1'b0;
            exc_q   <= '0;
            sw_ip_q <= '0;
            hw_ip_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            bd_q    <= bd_d;
            exc_q   <= exc_d;
            sw_ip_q <= sw_ip_d;
            hw_ip_q <= ip;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign ip_all = {hw_ip_q, sw_ip_q};

    always_comb begin
        read_data                       = '0;
        read_data[BD_BIT]               = bd_q;
        read_data[IP_LSB +: IP_WIDTH]   = ip_all;
        read_data[EXC_LSB +: EXC_W]     = exc_q;
    end

    assign irq            = ie & (|(ip_all & im));
    assign nest_overflow  = ovf_q;
    assign nest_underflow = unf_q;

endmodule
